// File: rtl/lsu_arb_pkg.sv
// Shared types and constants for the two-port LSU arbiter.
// Request bundle layout, port indices and funct3 access encodings.
package lsu_arb_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wren;
        logic [2:0]  funct3;
    } lsu_req_t;

    localparam logic PORT_PIPE = 1'b0;
    localparam logic PORT_AUX  = 1'b1;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/lsu_arb_starve.sv
// Starvation counter for the secondary port: counts consecutive denied cycles,
// saturates at STARVE_MAX, and raises o_force once the limit is reached.
module lsu_arb_starve
    import lsu_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_p1_valid,
    input  logic             i_p1_grant,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_force
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (i_p1_valid && !i_p1_grant) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt   = cnt_q;
    assign o_force = (cnt_q == CNT_MAX);

endmodule

// File: rtl/lsu_arbiter.sv
// Shares the single LSU port between the MEM stage (port 0) and a loader/DMA (port 1).
// Same-cycle combinational grant; load data returns one cycle later tagged to its owner.
module lsu_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,

    input  logic             i_p0_valid,
    input  logic [31:0]      i_p0_addr,
    input  logic [31:0]      i_p0_wdata,
    input  logic             i_p0_wren,
    input  logic [2:0]       i_p0_funct3,
    output logic             o_p0_ready,
    output logic             o_p0_stall,
    output logic             o_p0_rvalid,

    input  logic             i_p1_valid,
    input  logic [31:0]      i_p1_addr,
    input  logic [31:0]      i_p1_wdata,
    input  logic             i_p1_wren,
    input  logic [2:0]       i_p1_funct3,
    output logic             o_p1_ready,
    output logic             o_p1_rvalid,

    output logic [31:0]      o_rdata,

    output logic [31:0]      o_lsu_addr,
    output logic [31:0]      o_lsu_st_data,
    output logic             o_lsu_wren,
    output logic             o_lsu_ren,
    output logic [2:0]       o_lsu_funct3,
    input  logic [31:0]      i_lsu_ld_data,

    output logic [CNT_W-1:0] o_starve_cnt
);

    lsu_req_t p0_req;
    lsu_req_t p1_req;
    lsu_req_t lsu_req;

    logic grant0;
    logic grant1;
    logic any_grant;
    logic force_p1;

    logic rd_pending_q, rd_pending_d;
    logic rd_owner_q,   rd_owner_d;

    assign p0_req = '{addr: i_p0_addr, wdata: i_p0_wdata, wren: i_p0_wren, funct3: i_p0_funct3};
    assign p1_req = '{addr: i_p1_addr, wdata: i_p1_wdata, wren: i_p1_wren, funct3: i_p1_funct3};

    // Port 0 has priority unless port 1 has waited STARVE_MAX cycles.
    assign grant1    = i_p1_valid && (!i_p0_valid || force_p1);
    assign grant0    = i_p0_valid && !grant1;
    assign any_grant = grant0 || grant1;

    always_comb begin
        lsu_req = '0;
        if (grant1) begin
            lsu_req = p1_req;
        end else if (grant0) begin
            lsu_req = p0_req;
        end
    end

    assign o_lsu_addr    = lsu_req.addr;
    assign o_lsu_st_data = lsu_req.wdata;
    assign o_lsu_funct3  = lsu_req.funct3;
    assign o_lsu_wren    = any_grant &&  lsu_req.wren;
    assign o_lsu_ren     = any_grant && !lsu_req.wren;

    assign o_p0_ready = grant0;
    assign o_p1_ready = grant1;
    assign o_p0_stall = i_p0_valid && !grant0;

    lsu_arb_starve #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_starve (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_p1_valid (i_p1_valid),
        .i_p1_grant (grant1),
        .o_cnt      (o_starve_cnt),
        .o_force    (force_p1)
    );

    always_comb begin
        rd_pending_d = o_lsu_ren;
        rd_owner_d   = rd_owner_q;
        if (o_lsu_ren) begin
            rd_owner_d = grant1 ? PORT_AUX : PORT_PIPE;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rd_pending_q <= 1'b0;
            rd_owner_q   <= PORT_PIPE;
        end else begin
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    // Load data is already registered inside the LSU, so it passes straight through.
    assign o_p0_rvalid = rd_pending_q && (rd_owner_q == PORT_PIPE);
    assign o_p1_rvalid = rd_pending_q && (rd_owner_q == PORT_AUX);
    assign o_rdata     = i_lsu_ld_data;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed plus randomized bench for lsu_arbiter against a rule-level reference model.
module tb_lsu_arbiter;
    import lsu_arb_pkg::*;

    localparam int SM = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_valid, p0_wren, p1_valid, p1_wren;
    logic [31:0]   p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [2:0]    p0_funct3, p1_funct3;
    logic          p0_ready, p0_stall, p0_rvalid, p1_ready, p1_rvalid;
    logic [31:0]   rdata, lsu_addr, lsu_st_data, lsu_ld_data;
    logic          lsu_wren, lsu_ren;
    logic [2:0]    lsu_funct3;
    logic [CW-1:0] starve_cnt;

    always #5 clk = ~clk;

    lsu_arbiter #(.STARVE_MAX(SM), .CNT_W(CW)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_p0_valid(p0_valid), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
        .i_p0_wren(p0_wren), .i_p0_funct3(p0_funct3),
        .o_p0_ready(p0_ready), .o_p0_stall(p0_stall), .o_p0_rvalid(p0_rvalid),
        .i_p1_valid(p1_valid), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
        .i_p1_wren(p1_wren), .i_p1_funct3(p1_funct3),
        .o_p1_ready(p1_ready), .o_p1_rvalid(p1_rvalid),
        .o_rdata(rdata),
        .o_lsu_addr(lsu_addr), .o_lsu_st_data(lsu_st_data), .o_lsu_wren(lsu_wren),
        .o_lsu_ren(lsu_ren), .o_lsu_funct3(lsu_funct3), .i_lsu_ld_data(lsu_ld_data),
        .o_starve_cnt(starve_cnt)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        owner;
        logic [31:0] data;
    } resp_t;

    resp_t       resp_q[$];
    int          denied = 0;
    logic        lsu_pend;
    logic [31:0] lsu_pend_addr;
    logic        last_g0, last_g1;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h0000_0010) ? 32'hDEADBEEF : ((a ^ 32'h5A5A_0000) + 32'h0000_1234);
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic set_p0(input logic v, input logic [31:0] a, input logic [31:0] d,
                          input logic w, input logic [2:0] f);
        p0_valid = v; p0_addr = a; p0_wdata = d; p0_wren = w; p0_funct3 = f;
    endtask

    task automatic set_p1(input logic v, input logic [31:0] a, input logic [31:0] d,
                          input logic w, input logic [2:0] f);
        p1_valid = v; p1_addr = a; p1_wdata = d; p1_wren = w; p1_funct3 = f;
    endtask

    // One clock: inputs were driven 1ns after the edge; check, advance the model, step.
    task automatic cycle();
        logic        g0, g1, have, e_wren;
        logic [31:0] e_addr, e_data;
        logic [2:0]  e_f3;
        resp_t       r;
        #3;
        g1 = p1_valid && (!p0_valid || denied == SM);
        g0 = p0_valid && !g1;
        e_addr = 32'h0; e_data = 32'h0; e_f3 = 3'b000; e_wren = 1'b0;
        if (g1) begin
            e_addr = p1_addr; e_data = p1_wdata; e_f3 = p1_funct3; e_wren = p1_wren;
        end else if (g0) begin
            e_addr = p0_addr; e_data = p0_wdata; e_f3 = p0_funct3; e_wren = p0_wren;
        end
        chk1("p0_ready", p0_ready, g0);
        chk1("p1_ready", p1_ready, g1);
        chk1("p0_stall", p0_stall, p0_valid && !g0);
        chk1("lsu_wren", lsu_wren, (g0 || g1) && e_wren);
        chk1("lsu_ren", lsu_ren, (g0 || g1) && !e_wren);
        chk32("lsu_addr", lsu_addr, e_addr);
        chk32("lsu_st_data", lsu_st_data, e_data);
        chk32("lsu_funct3", {29'b0, lsu_funct3}, {29'b0, e_f3});
        chk32("starve_cnt", 32'(starve_cnt), 32'(denied));
        have = (resp_q.size() > 0);
        r = '{owner: 1'b0, data: 32'h0};
        if (have) r = resp_q.pop_front();
        chk1("p0_rvalid", p0_rvalid, have && r.owner == 1'b0);
        chk1("p1_rvalid", p1_rvalid, have && r.owner == 1'b1);
        if (have) chk32("rdata", rdata, r.data);
        if ((g0 || g1) && !e_wren) resp_q.push_back('{owner: g1, data: mem_fn(e_addr)});
        denied = (p1_valid && !g1) ? ((denied + 1 > SM) ? SM : denied + 1) : 0;
        last_g0 = g0;
        last_g1 = g1;
        lsu_pend = lsu_ren;
        lsu_pend_addr = lsu_addr;
        @(posedge clk);
        #1;
        lsu_ld_data = lsu_pend ? mem_fn(lsu_pend_addr) : $urandom;
    endtask

    initial begin
        rst = 1'b1;
        lsu_ld_data = 32'h0;
        set_p0(1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
        set_p1(1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
        #2;
        chk1("rst_p0_rvalid", p0_rvalid, 1'b0);
        chk1("rst_p1_rvalid", p1_rvalid, 1'b0);
        chk32("rst_starve_cnt", 32'(starve_cnt), 32'd0);
        chk1("rst_lsu_ren", lsu_ren, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Port 0 load alone, then idle to collect the response.
        set_p0(1'b1, 32'h0000_0010, 32'h0, 1'b0, LW);
        cycle();
        set_p0(1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
        cycle();

        // Both ports valid continuously: port 1 forced in on the fifth cycle.
        for (int i = 0; i < 5; i++) begin
            set_p0(1'b1, 32'h100 + 32'(4 * i), 32'h0, 1'b0, LW);
            set_p1(1'b1, 32'h0000_0200, 32'h0, 1'b0, LH);
            cycle();
        end
        set_p0(1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
        set_p1(1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
        cycle();

        // Alternating reads on consecutive cycles.
        set_p0(1'b1, 32'h0000_0020, 32'h0, 1'b0, LW);
        cycle();
        set_p0(1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
        set_p1(1'b1, 32'h0000_0024, 32'h0, 1'b0, LW);
        cycle();
        set_p1(1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
        cycle();
        cycle();

        // Port 1 store, then a read followed immediately by a store.
        set_p1(1'b1, 32'h1000_0000, 32'h0000_00FF, 1'b1, SW);
        cycle();
        set_p1(1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
        set_p0(1'b1, 32'h0000_0030, 32'h0, 1'b0, LBU);
        cycle();
        set_p0(1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
        set_p1(1'b1, 32'h1000_0004, 32'hCAFE_F00D, 1'b1, SB);
        cycle();
        set_p1(1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
        cycle();

        // Port 1 alone: immediate grant, counter stays at zero.
        set_p1(1'b1, 32'h0000_0400, 32'h0, 1'b0, LHU);
        cycle();
        set_p1(1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
        cycle();

        // Reset lands in the cycle after a granted p0 read.
        set_p0(1'b1, 32'h0000_0044, 32'h0, 1'b0, LW);
        set_p1(1'b1, 32'h0000_0048, 32'h0, 1'b0, LW);
        cycle();
        set_p0(1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
        set_p1(1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
        rst = 1'b1;
        #3;
        chk1("midrst_p0_rvalid", p0_rvalid, 1'b0);
        chk1("midrst_p1_rvalid", p1_rvalid, 1'b0);
        chk32("midrst_starve_cnt", 32'(starve_cnt), 32'd0);
        resp_q.delete();
        denied = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        cycle();

        // Randomized traffic; an unaccepted request is held stable until granted.
        for (int n = 0; n < 400; n++) begin
            if (!(p0_valid && !last_g0)) begin
                set_p0($urandom_range(0, 9) < 6, $urandom, $urandom,
                       1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            end
            if (!(p1_valid && !last_g1)) begin
                set_p1($urandom_range(0, 9) < 7, $urandom, $urandom,
                       1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            end
            cycle();
        end
        set_p0(1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
        set_p1(1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
        cycle();
        chk32("resp_queue_drained", 32'(resp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
